// File: rtl/frame_scanout_if.sv
// Bus between frame_scanout, the frame_buf read port and the video sink.
// rd_en_out low for one cycle requests one pixel; frame_buf answers on pix_in the following cycle, with no back-pressure.
interface frame_scanout_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  frame_rdy;
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  rd_en_out;
  logic [DATA_WIDTH-1:0] pix_out;
  logic                  de;
  logic                  hsync;
  logic                  vsync;
  logic                  underrun;

  modport master (
    input  frame_rdy, pix_in,
    output rd_en_out, pix_out, de, hsync, vsync, underrun
  );

  modport slave (
    output frame_rdy, pix_in,
    input  rd_en_out, pix_out, de, hsync, vsync, underrun
  );
endinterface

// File: rtl/frame_scanout.sv
// Raster scan-out engine: counts h/v timing, strobes frame_buf reads for visible pixels
// and emits registered pixel/de/hsync/vsync aligned three cycles after the counters.
module frame_scanout #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 4,
  parameter int H_FP       = 1,
  parameter int H_SYNC     = 1,
  parameter int H_BP       = 1,
  parameter int V_ACTIVE   = 2,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 1,
  parameter int V_BP       = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               reset,
  frame_scanout_if.master    bus,
  output logic [1:0]         state_dbg
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_WIDTH-1:0] H_LAST  = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST  = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_ACT   = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_ACT   = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] HS_BEG  = CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CNT_WIDTH-1:0] HS_END  = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] VS_BEG  = CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CNT_WIDTH-1:0] VS_END  = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] h_cnt;
  logic [CNT_WIDTH-1:0] v_cnt;

  // Stage 1 travels with rd_en_out; stage 2 travels with pix_in.
  logic s1_de, s1_hs, s1_vs;
  logic s2_de, s2_hs, s2_vs, s2_rd;

  logic running, visible, hs_win, vs_win, h_last, v_last;

  assign running = (state != IDLE);
  assign visible = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_win  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_win  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign h_last  = (h_cnt == H_LAST);
  assign v_last  = (v_cnt == V_LAST);

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      h_cnt         <= '0;
      v_cnt         <= '0;
      s1_de         <= 1'b0;
      s1_hs         <= 1'b0;
      s1_vs         <= 1'b0;
      s2_de         <= 1'b0;
      s2_hs         <= 1'b0;
      s2_vs         <= 1'b0;
      s2_rd         <= 1'b0;
      bus.rd_en_out <= 1'b1;
      bus.pix_out   <= {DATA_WIDTH{1'b0}};
      bus.de        <= 1'b0;
      bus.hsync     <= 1'b1;
      bus.vsync     <= 1'b1;
      bus.underrun  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.frame_rdy) state <= SCAN;
        end
        default: begin
          h_cnt <= h_last ? '0 : h_cnt + CNT_WIDTH'(1);
          if (h_last) v_cnt <= v_last ? '0 : v_cnt + CNT_WIDTH'(1);
          // frame_rdy only matters at the frame boundary; mid-frame changes are ignored.
          if (h_last && v_last) begin
            if (bus.frame_rdy) begin
              state <= SCAN;
            end else begin
              state        <= BLANK;
              bus.underrun <= 1'b1;
            end
          end
        end
      endcase

      bus.rd_en_out <= ~((state == SCAN) && visible);
      s1_de         <= running && visible;
      s1_hs         <= running && hs_win;
      s1_vs         <= running && vs_win;

      s2_de <= s1_de;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_rd <= ~bus.rd_en_out;

      // Only pixels that were actually read reach the output; blank frames show zero.
      bus.pix_out <= s2_rd ? bus.pix_in : {DATA_WIDTH{1'b0}};
      bus.de      <= s2_de;
      bus.hsync   <= ~s2_hs;
      bus.vsync   <= ~s2_vs;
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: a frame_buf read model feeds a pixel scoreboard,
// and each scenario task checks strobe, de and sync timing against cycle offsets.
module tb_frame_scanout;
  localparam int DW = 24;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;

  int cyc    = 0;
  int c0     = 0;
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            rd_addr = 0;

  int            log_strobe[$];
  int            log_de[$];
  int            log_hs[$];
  int            log_vs[$];
  logic [DW-1:0] log_pix[$];
  int            log_badpix;
  bit            log_unr_seen;
  int            log_unr_first;

  frame_scanout_if #(.DATA_WIDTH(DW)) bus ();

  frame_scanout #(
    .DATA_WIDTH(DW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .CNT_WIDTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // frame_buf read model: data = address + 0x10, one cycle after each strobe
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr    <= 0;
      bus.pix_in <= '0;
      exp_q.delete();
    end else if (bus.rd_en_out == 1'b0) begin
      bus.pix_in <= DW'(rd_addr + 16);
      exp_q.push_back(DW'(rd_addr + 16));
      rd_addr    <= (rd_addr + 1) % 8;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    log_strobe.delete();
    log_de.delete();
    log_hs.delete();
    log_vs.delete();
    log_pix.delete();
    log_badpix    = 0;
    log_unr_seen  = 1'b0;
    log_unr_first = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.frame_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic start_scan();
    @(negedge clk);
    bus.frame_rdy = 1'b1;
    c0 = cyc;
  endtask

  // Samples outputs mid-cycle and records events as cycle offsets from c0.
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bus.rd_en_out === 1'b0) log_strobe.push_back(cyc - c0);
      if (bus.de === 1'b1) begin
        log_de.push_back(cyc - c0);
        log_pix.push_back(bus.pix_out);
      end else if (bus.pix_out !== '0) begin
        log_badpix++;
      end
      if (bus.hsync === 1'b0) log_hs.push_back(cyc - c0);
      if (bus.vsync === 1'b0) log_vs.push_back(cyc - c0);
      if (bus.underrun === 1'b1 && !log_unr_seen) begin
        log_unr_seen  = 1'b1;
        log_unr_first = cyc - c0;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.frame_rdy = 1'b0;
    #1;
    checks++; if (bus.rd_en_out !== 1'b1) begin errors++; $display("FAIL reset_rd_en: got %b expected 1", bus.rd_en_out); end
    checks++; if (bus.hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", bus.hsync); end
    checks++; if (bus.vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", bus.vsync); end
    checks++; if (bus.de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", bus.de); end
    checks++; if (bus.pix_out !== '0) begin errors++; $display("FAIL reset_pix: got %h expected 0", bus.pix_out); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", bus.underrun); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clear_logs();
    c0 = cyc;
    run_cycles(50);
    checks++; if (log_strobe.size() != 0) begin errors++; $display("FAIL idle_strobes: got %0d expected 0", log_strobe.size()); end
    checks++; if (log_de.size() != 0) begin errors++; $display("FAIL idle_de: got %0d expected 0", log_de.size()); end
    checks++; if (log_hs.size() != 0) begin errors++; $display("FAIL idle_hsync: got %0d low cycles expected 0", log_hs.size()); end
    checks++; if (log_vs.size() != 0) begin errors++; $display("FAIL idle_vsync: got %0d low cycles expected 0", log_vs.size()); end
    checks++; if (log_badpix != 0) begin errors++; $display("FAIL idle_pix: got %0d nonzero cycles expected 0", log_badpix); end
    checks++; if (log_unr_seen) begin errors++; $display("FAIL idle_underrun: got 1 expected 0"); end
  endtask

  task automatic test_single_frame();
    int e;
    logic [DW-1:0] ep;
    do_reset();
    start_scan();
    run_cycles(35);
    checks++; if (log_strobe.size() != 8) begin errors++; $display("FAIL sf_strobe_count: got %0d expected 8", log_strobe.size()); end
    foreach (log_strobe[i]) begin
      e = (i < 4) ? 2 + i : 9 + i - 4;
      checks++; if (log_strobe[i] != e) begin errors++; $display("FAIL sf_strobe_time[%0d]: got %0d expected %0d", i, log_strobe[i], e); end
    end
    checks++; if (log_de.size() != 8) begin errors++; $display("FAIL sf_de_count: got %0d expected 8", log_de.size()); end
    foreach (log_de[i]) begin
      e = (i < 4) ? 4 + i : 11 + i - 4;
      checks++; if (log_de[i] != e) begin errors++; $display("FAIL sf_de_time[%0d]: got %0d expected %0d", i, log_de[i], e); end
    end
    foreach (log_pix[i]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sf_pix[%0d]: got %h expected none queued", i, log_pix[i]);
      end else begin
        ep = exp_q.pop_front();
        if (log_pix[i] !== ep || log_pix[i] !== DW'(16 + i)) begin
          errors++; $display("FAIL sf_pix[%0d]: got %h expected %h", i, log_pix[i], DW'(16 + i));
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sf_sb_leftover: got %0d expected 0", exp_q.size()); end
    checks++; if (log_hs.size() != 4) begin errors++; $display("FAIL sf_hs_count: got %0d expected 4", log_hs.size()); end
    foreach (log_hs[i]) begin
      e = 9 + 7 * i;
      checks++; if (log_hs[i] != e) begin errors++; $display("FAIL sf_hs_time[%0d]: got %0d expected %0d", i, log_hs[i], e); end
    end
    checks++; if (log_vs.size() != 7) begin errors++; $display("FAIL sf_vs_count: got %0d expected 7", log_vs.size()); end
    foreach (log_vs[i]) begin
      e = 25 + i;
      checks++; if (log_vs[i] != e) begin errors++; $display("FAIL sf_vs_time[%0d]: got %0d expected %0d", i, log_vs[i], e); end
    end
    checks++; if (log_badpix != 0) begin errors++; $display("FAIL sf_pix_outside_de: got %0d expected 0", log_badpix); end
  endtask

  task automatic test_continuous();
    logic [DW-1:0] ep;
    do_reset();
    start_scan();
    run_cycles(105);
    checks++; if (log_strobe.size() != 24) begin errors++; $display("FAIL cont_strobe_count: got %0d expected 24", log_strobe.size()); end
    checks++; if (log_de.size() != 24) begin errors++; $display("FAIL cont_de_count: got %0d expected 24", log_de.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (log_de.size() <= 8 * k || log_de[8 * k] != 4 + 35 * k) begin
        errors++; $display("FAIL cont_frame_de_rise[%0d]: got %0d expected %0d", k, (log_de.size() > 8 * k) ? log_de[8 * k] : -1, 4 + 35 * k);
      end
    end
    foreach (log_pix[i]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL cont_pix[%0d]: got %h expected none queued", i, log_pix[i]);
      end else begin
        ep = exp_q.pop_front();
        if (log_pix[i] !== ep || log_pix[i] !== DW'(16 + (i % 8))) begin
          errors++; $display("FAIL cont_pix[%0d]: got %h expected %h", i, log_pix[i], DW'(16 + (i % 8)));
        end
      end
    end
    checks++; if (log_unr_seen) begin errors++; $display("FAIL cont_underrun: got 1 expected 0"); end
  endtask

  task automatic test_underrun();
    int n_str, n_de, first_de, n_hs, n_vs, n_f0, n_f2;
    logic [DW-1:0] ep;
    do_reset();
    start_scan();
    run_cycles(20);
    bus.frame_rdy = 1'b0;
    run_cycles(29);
    bus.frame_rdy = 1'b1;
    run_cycles(56);
    checks++; if (log_unr_first != 36) begin errors++; $display("FAIL ur_set_time: got %0d expected 36", log_unr_first); end
    checks++; if (bus.underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b expected 1", bus.underrun); end
    n_str = 0; n_f0 = 0; n_f2 = 0;
    foreach (log_strobe[i]) begin
      if (log_strobe[i] >= 36 && log_strobe[i] <= 71) n_str++;
      else if (log_strobe[i] < 36) n_f0++;
      else n_f2++;
    end
    checks++; if (n_str != 0) begin errors++; $display("FAIL ur_blank_strobes: got %0d expected 0", n_str); end
    checks++; if (n_f0 != 8) begin errors++; $display("FAIL ur_frame0_strobes: got %0d expected 8", n_f0); end
    checks++; if (n_f2 != 8) begin errors++; $display("FAIL ur_frame2_strobes: got %0d expected 8", n_f2); end
    n_de = 0; first_de = -1; n_hs = 0; n_vs = 0;
    foreach (log_de[i]) if (log_de[i] >= 36 && log_de[i] <= 73) begin
      if (first_de < 0) first_de = log_de[i];
      n_de++;
    end
    foreach (log_hs[i]) if (log_hs[i] >= 39 && log_hs[i] <= 73) n_hs++;
    foreach (log_vs[i]) if (log_vs[i] >= 39 && log_vs[i] <= 73) n_vs++;
    checks++; if (n_de != 8) begin errors++; $display("FAIL ur_blank_de: got %0d expected 8", n_de); end
    checks++; if (first_de != 39) begin errors++; $display("FAIL ur_blank_de_first: got %0d expected 39", first_de); end
    checks++; if (n_hs != 5) begin errors++; $display("FAIL ur_blank_hsync: got %0d expected 5", n_hs); end
    checks++; if (n_vs != 7) begin errors++; $display("FAIL ur_blank_vsync: got %0d expected 7", n_vs); end
    foreach (log_de[i]) begin
      checks++;
      if (log_de[i] >= 39 && log_de[i] <= 73) begin
        if (log_pix[i] !== '0) begin errors++; $display("FAIL ur_blank_pix[%0d]: got %h expected 0", i, log_pix[i]); end
      end else if (exp_q.size() == 0) begin
        errors++; $display("FAIL ur_pix[%0d]: got %h expected none queued", i, log_pix[i]);
      end else begin
        ep = exp_q.pop_front();
        if (log_pix[i] !== ep) begin errors++; $display("FAIL ur_pix[%0d]: got %h expected %h", i, log_pix[i], ep); end
      end
    end
  endtask

  task automatic test_midframe_toggle();
    int e, n;
    logic [DW-1:0] ep;
    do_reset();
    start_scan();
    run_cycles(2);
    bus.frame_rdy = 1'b0;
    run_cycles(3);
    bus.frame_rdy = 1'b1;
    run_cycles(33);
    n = 0;
    foreach (log_strobe[i]) if (log_strobe[i] < 36) begin
      e = (n < 4) ? 2 + n : 9 + n - 4;
      checks++; if (log_strobe[i] != e) begin errors++; $display("FAIL tog_strobe_time[%0d]: got %0d expected %0d", n, log_strobe[i], e); end
      n++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL tog_strobe_count: got %0d expected 8", n); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL tog_underrun: got %b expected 0", bus.underrun); end
    foreach (log_pix[i]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL tog_pix[%0d]: got %h expected none queued", i, log_pix[i]);
      end else begin
        ep = exp_q.pop_front();
        if (log_pix[i] !== ep) begin errors++; $display("FAIL tog_pix[%0d]: got %h expected %h", i, log_pix[i], ep); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int e;
    logic [DW-1:0] ep;
    do_reset();
    start_scan();
    run_cycles(9);
    reset = 1'b0;
    #1;
    checks++; if (bus.rd_en_out !== 1'b1) begin errors++; $display("FAIL rmf_rd_en: got %b expected 1", bus.rd_en_out); end
    checks++; if (bus.hsync !== 1'b1) begin errors++; $display("FAIL rmf_hsync: got %b expected 1", bus.hsync); end
    checks++; if (bus.vsync !== 1'b1) begin errors++; $display("FAIL rmf_vsync: got %b expected 1", bus.vsync); end
    checks++; if (bus.de !== 1'b0) begin errors++; $display("FAIL rmf_de: got %b expected 0", bus.de); end
    checks++; if (bus.pix_out !== '0) begin errors++; $display("FAIL rmf_pix: got %h expected 0", bus.pix_out); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
    c0 = cyc;
    run_cycles(35);
    checks++; if (log_strobe.size() != 8) begin errors++; $display("FAIL rmf_strobe_count: got %0d expected 8", log_strobe.size()); end
    foreach (log_strobe[i]) begin
      e = (i < 4) ? 2 + i : 9 + i - 4;
      checks++; if (log_strobe[i] != e) begin errors++; $display("FAIL rmf_strobe_time[%0d]: got %0d expected %0d", i, log_strobe[i], e); end
    end
    checks++; if (log_de.size() == 0 || log_de[0] != 4) begin errors++; $display("FAIL rmf_de_first: got %0d expected 4", (log_de.size() > 0) ? log_de[0] : -1); end
    foreach (log_pix[i]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL rmf_pix[%0d]: got %h expected none queued", i, log_pix[i]);
      end else begin
        ep = exp_q.pop_front();
        if (log_pix[i] !== ep || log_pix[i] !== DW'(16 + i)) begin
          errors++; $display("FAIL rmf_pix[%0d]: got %h expected %h", i, log_pix[i], DW'(16 + i));
        end
      end
    end
    checks++; if (log_badpix != 0) begin errors++; $display("FAIL rmf_pix_outside_de: got %0d expected 0", log_badpix); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.frame_rdy = 1'b0;
    clear_logs();
    test_reset();
    test_single_frame();
    test_continuous();
    test_underrun();
    test_midframe_toggle();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_scanout.md
# frame_scanout

Single-clock display scan-out engine on the read side of `frame_buf`. It runs horizontal and vertical raster counters and drives the buffer's active-low read enable, one strobe per visible pixel. It re-registers the returned pixels and emits them with aligned `de`, `hsync` and `vsync`. It is the consumer that drains one buffered frame per raster frame and free-wheels blank frames when no complete frame is available.

## Interface
- `DATA_WIDTH`, 24: pixel width; must match `frame_buf`.
- `H_ACTIVE`, 4: visible pixels per line.
- `H_FP`, 1 / `H_SYNC`, 1 / `H_BP`, 1: horizontal front porch, sync and back porch, in clocks. Each is ≥1.
- `V_ACTIVE`, 2: visible lines per frame. `H_ACTIVE*V_ACTIVE` equals the `frame_buf` `MEM_DEPTH`.
- `V_FP`, 1 / `V_SYNC`, 1 / `V_BP`, 1: vertical porches and sync, in lines. Each is ≥1.
- `CNT_WIDTH`, 8: counter width. Must hold `H_TOTAL-1` and `V_TOTAL-1`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (`ASSERT` = 1'b0).
- `frame_rdy` in 1: high = buffer holds a complete frame.
- `pix_in` in DATA_WIDTH: read data from `frame_buf`. Valid the cycle after a `rd_en_out` strobe.
- `rd_en_out` out 1: active-low read strobe to `frame_buf` `rd_en_in`. Reset value 1.
- `pix_out` out DATA_WIDTH: pixel. Reset value 0; forced to 0 whenever `de`=0 or in BLANK.
- `de` out 1: active-high data enable. Reset value 0.
- `hsync`, `vsync` out 1 each: active-low syncs. Reset value 1.
- `underrun` out 1: sticky; set when a frame starts in BLANK. Reset value 0; cleared only by reset.

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`, `V_TOTAL` likewise.
- `h_cnt` runs 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments on each `h_cnt` wrap and wraps to 0 after V_TOTAL-1.
- Region order on each axis: active [0, ACTIVE), front porch, sync, back porch.
- Visible pixel: `h_cnt<H_ACTIVE && v_cnt<V_ACTIVE`.
- Sync windows: hsync region `H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC`; vsync region defined the same way on `v_cnt`.
- Frame boundary: the cycle with `h_cnt=H_TOTAL-1 && v_cnt=V_TOTAL-1`.
- States:
  - IDLE: counters held at 0; all outputs at reset values. Moves to SCAN on the first cycle `frame_rdy`=1. Counters start running from (0,0) on the next cycle.
  - SCAN: counters run. `rd_en_out` is strobed for each visible pixel.
  - BLANK: counters run and syncs are generated. `rd_en_out` stays 1, `de` follows timing, `pix_out`=0.
- Frame-boundary decision, taken only at the frame boundary (`frame_rdy` is ignored mid-frame):
  - `frame_rdy`=1 → SCAN.
  - `frame_rdy`=0 → BLANK, and `underrun` is set.
- IDLE is re-entered only through reset.
- Each SCAN frame issues exactly `H_ACTIVE*V_ACTIVE` strobes, matching one full `frame_buf` read burst, so the buffer's read address returns to 0.
- Reset assertion mid-frame: all outputs take their reset values immediately (asynchronously), counters clear, state goes to IDLE. The pipeline contents are discarded.

## Timing
- Counters at (h,v) in cycle n give:
  - `rd_en_out`=0 in cycle n+1, if visible and in SCAN.
  - `pix_in` valid in cycle n+2.
  - `pix_out`, `de`, `hsync`, `vsync` in cycle n+3, all registered and mutually aligned.
- Video outputs lag `rd_en_out` by exactly 2 cycles.
- `rd_en_out` is low for `H_ACTIVE` consecutive cycles per visible line and never low outside visible positions.
- Pipeline flush on SCAN→BLANK: pixels already in flight from the last SCAN line complete normally.
- First `de` after leaving IDLE: 4 cycles after the cycle in which `frame_rdy` is first sampled high.
- Frame period is `H_TOTAL*V_TOTAL` clocks (35 with defaults). `hsync` is low 1 clock per line and `vsync` is low `H_TOTAL` clocks per frame.

## Test plan
- **Reset values:** hold reset low → `rd_en_out`=1, `hsync`=`vsync`=1, `de`=0, `pix_out`=0, `underrun`=0; release reset with `frame_rdy`=0 for 50 clocks → outputs unchanged.
- **Single frame with defaults:** hold `frame_rdy`=1; model buffer returning `pix_in`=address+0x10 one cycle after each strobe.
  - Required: 8 strobes in 2 bursts of 4, 7 clocks apart.
  - `de` high 4 clocks per line, with `pix_out` = 0x10..0x17 in order.
  - `hsync` low 1 clock at line offset 5 (relative to `de` rise); `vsync` low for lines 3 only.
- **Continuous frames:** `frame_rdy`=1 for 3 frames → exactly 24 strobes; `de` rises every 35 clocks for the first line of each frame; `underrun` stays 0.
- **Underrun:** drop `frame_rdy` to 0 before the second frame boundary.
  - Required: the second frame has syncs and `de` as normal, `pix_out`=0, no strobes, and `underrun`=1 from the boundary onward.
  - Raise `frame_rdy` mid-frame → no strobes until the next boundary.
- **Mid-frame `frame_rdy` toggle:** pulse `frame_rdy` low during the active region of a SCAN frame → that frame still issues all 8 strobes.
- **Reset mid-frame:** assert reset during the second visible line → outputs return to reset values in the same cycle; after release with `frame_rdy`=1, scan restarts at (0,0) with a full 8-strobe frame.
